// File: rtl/md_unit.sv
// rtl/md_unit.sv - MIPS EX-stage multiply/divide unit owning HI/LO (optional MDU_MADD_EN adds madd/maddu/msub/msubu)
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [31:0] res_hi, res_lo;
    logic        wr_en;

    logic        is_mul, is_div, is_md;
    logic [3:0]  lat;
    logic [63:0] prod_s, prod_u, res_calc;
    logic [31:0] b_nz;
    logic signed [31:0] q_s, r_s;
    logic        div_ovf;

    always_comb begin
        is_mul = (md_op == 4'd1) || (md_op == 4'd2);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (md_op >= 4'd7 && md_op <= 4'd10);
`endif
        is_div = (md_op == 4'd3) || (md_op == 4'd4);
        is_md  = is_mul || is_div;
        lat    = is_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
    end

    // Divisor forced non-zero so the divider never sees 0; the result is discarded via wr_en anyway.
    assign b_nz    = (b == 32'd0) ? 32'd1 : b;
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u  = {32'd0, a} * {32'd0, b};

    always_comb begin
        if (div_ovf) begin
            q_s = 32'sh8000_0000;
            r_s = 32'sd0;
        end else begin
            q_s = $signed(a) / $signed(b_nz);
            r_s = $signed(a) % $signed(b_nz);
        end
    end

    always_comb begin
        res_calc = 64'd0;
        case (md_op)
            4'd1:    res_calc = prod_s;
            4'd2:    res_calc = prod_u;
            4'd3:    res_calc = {r_s, q_s};
            4'd4:    res_calc = {a % b_nz, a / b_nz};
`ifdef MDU_MADD_EN
            4'd7:    res_calc = {HI, LO} + prod_s;
            4'd8:    res_calc = {HI, LO} + prod_u;
            4'd9:    res_calc = {HI, LO} - prod_s;
            4'd10:   res_calc = {HI, LO} - prod_u;
`endif
            default: res_calc = 64'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && is_md) state_nxt = RUN;
            RUN:     if (cnt <= 4'd1)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        stall_req = busy || (start && is_md);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            HI     <= 32'd0;
            LO     <= 32'd0;
            cnt    <= 4'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            wr_en  <= 1'b0;
        end else if (state == IDLE) begin
            if (start && is_md) begin
                {res_hi, res_lo} <= res_calc;
                cnt              <= lat;
                wr_en            <= !(is_div && (b == 32'd0));
            end else if (start && md_op == 4'd5) begin
                HI <= a;
            end else if (start && md_op == 4'd6) begin
                LO <= a;
            end
        end else begin
            cnt <= cnt - 4'd1;
            if (cnt <= 4'd1 && wr_en) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end
    end
endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the five-stage MIPS pipeline, sitting in the EX stage beside the ALU. It executes mult/multu/div/divu with fixed multi-cycle latency and owns the architectural HI/LO registers. It drives the `busy`/`stall_req` indication that the hazard logic turns into the `stall` of the ID/EX pipeline register. HI/LO outputs feed the EX-stage HI/LO fields carried down the pipeline.

## Interface

- `MUL_CYCLES`, 5, busy cycles for mult/multu (and madd-family when enabled)
- `DIV_CYCLES`, 10, busy cycles for div/divu
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-low reset
- `start`  input  1  single-cycle request; `md_op`, `a`, `b` valid with it
- `md_op`  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu
- `a`  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- `b`  input  32  rt operand (divisor / multiplier)
- `busy`  output  1  registered; high while an operation is in flight
- `stall_req`  output  1  combinational: `busy | (start & md_op in mult/div/madd family)`
- `HI`  output  32  registered HI
- `LO`  output  32  registered LO

## Operation

- States: IDLE, RUN. Down-counter `cnt` (4 bits), pending result `res_hi/res_lo`, pending-commit flag `wr_en`.
- IDLE, `start` with mult/multu/div/divu: latch result of full operation into `res_*`, load `cnt` with latency, go RUN, `busy` <= 1.
- RUN: decrement `cnt`; at `cnt == 1` commit `res_*` to HI/LO (if `wr_en`), `busy` <= 0, return IDLE.
- `start` while `busy`: ignored entirely (all ops, including mthi/mtlo). Hazard logic must not issue it; unit guarantees no corruption.
- mthi/mtlo in IDLE: HI (resp. LO) <= `a` at that edge; `busy` stays 0.
- md_op 0 or unsupported code with `start`: no effect.
- Arithmetic:
  - mult: {HI,LO} = $signed(a) * $signed(b), 64-bit.
  - multu: unsigned 64-bit product.
  - div: LO = quotient truncated toward zero, HI = remainder with sign of dividend.
  - divu: unsigned quotient/remainder.
  - `b == 0` for div/divu: `wr_en` = 0, HI/LO unchanged, still busy for `DIV_CYCLES`.
  - 0x80000000 / 0xFFFFFFFF (div): LO = 0x80000000, HI = 0.
- Reset (`rst` low at edge, any state incl. RUN): HI = 0, LO = 0, `busy` = 0, `cnt` = 0, state IDLE, pending result discarded.

## Timing

- Edge E0 samples `start`. `busy` high from cycle after E0 for exactly N cycles (N = `MUL_CYCLES` or `DIV_CYCLES`).
- New HI/LO visible in the same cycle `busy` first reads 0 (N+1 cycles after the start cycle).
- `stall_req` high in the start cycle itself and all N busy cycles.
- mthi/mtlo: HI/LO visible one cycle after the start cycle.
- Back-to-back: a new `start` is accepted in the first cycle `busy` is 0.
- Reset values: `busy` 0, `HI` 0, `LO` 0; `stall_req` follows inputs.

## Configuration

- `MDU_MADD_EN` defined: md_op 7–10 accepted; latency `MUL_CYCLES`.
  - madd: {HI,LO} += signed product.
  - maddu: {HI,LO} += unsigned product.
  - msub: {HI,LO} -= signed product.
  - msubu: {HI,LO} -= unsigned product.
  - Accumulation uses HI/LO as held at the start edge; 64-bit wrap-around.
- Not defined: codes 7–10 treated as md_op 0. No busy, no `stall_req`, HI/LO unchanged.

## Test plan

- mult a=0xFFFFFFFF b=2 -> `busy` high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; multu same operands -> HI=0x00000001 LO=0xFFFFFFFE.
- div a=0xFFFFFFF9 (-7) b=2 -> `busy` 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; divu a=7 b=0 -> busy 10 cycles, HI/LO keep prior values.
- Start div, then mthi a=0x1234 and mult during busy -> both ignored; after 10 cycles only the div result present; `stall_req` high throughout.
- Start mult, drive `rst`=0 at busy cycle 3 -> next cycle `busy`=0, HI=LO=0, no later commit.
- mtlo a=0xDEADBEEF then mult issued the cycle after -> LO=0xDEADBEEF visible immediately; mult accepted, result overwrites after 5 cycles.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, maddu a=1 b=1 -> HI=1 LO=0. Without the macro: same stimulus -> no busy, HI/LO unchanged.
